// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel synchroniser, glitch filter and edge detector
// with sticky per-channel event flags and an OR-ed interrupt.
//
// Optional build macro: EDGE_DETECT_CNT_EN
//   When defined, adds output evt_cnt (8 bits per channel). Each channel's counter
//   increments on every mode-enabled edge and saturates at 255.
//   When undefined, the port and the counters are not built.

// ---------------------------------------------------------------------------
// Per-channel slice: sync chain, glitch filter, edge pulses, sticky flag.
// ---------------------------------------------------------------------------
module edge_detect_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a,
  input  logic              i_warm,
  input  logic [1:0]        i_mode,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic              i_clr,
  output logic              o_rise,
  output logic              o_down,
  output logic              o_pend
`ifdef EDGE_DETECT_CNT_EN
  ,
  output logic [7:0]        o_cnt
`endif
);

  logic [SYNC_STAGES-1:0] r_sync;   // [0] samples the pin, [SYNC_STAGES-1] is sync_out
  logic                   r_lvl;    // filtered level
  logic [FILT_W-1:0]      r_cnt;    // consecutive cycles sync_out has disagreed with r_lvl
  logic                   w_so;
  logic                   w_so_nxt;
  logic                   w_fire;
  logic                   w_set;

  assign w_so     = r_sync[SYNC_STAGES-1];
  // Value sync_out takes after this edge; warm-up tracks it so the filtered
  // level already agrees with sync_out on the first live cycle.
  assign w_so_nxt = r_sync[SYNC_STAGES-2];

  // >= rather than == so that lowering filt_len mid-count fires at once.
  assign w_fire   = !i_warm && (w_so != r_lvl) && (r_cnt >= i_filt_len);
  // Mode bit 0 enables rising events, bit 1 enables falling events.
  assign w_set    = w_fire && (w_so ? i_mode[0] : i_mode[1]);

  // Synchroniser shift chain.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_a};
  end

  // Glitch filter and registered edge pulses (pulses are not gated by mode).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl  <= 1'b0;
      r_cnt  <= '0;
      o_rise <= 1'b0;
      o_down <= 1'b0;
    end else begin
      o_rise <= w_fire &  w_so;
      o_down <= w_fire & ~w_so;
      if (i_warm) begin
        r_lvl <= w_so_nxt;
        r_cnt <= '0;
      end else if (w_so == r_lvl) begin
        r_cnt <= '0;
      end else if (w_fire) begin
        r_lvl <= w_so;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + FILT_W'(1);
      end
    end
  end

  // Sticky flag: a new event beats a coincident clear so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst)        o_pend <= 1'b0;
    else if (w_set) o_pend <= 1'b1;
    else if (i_clr) o_pend <= 1'b0;
  end

`ifdef EDGE_DETECT_CNT_EN
  // Saturating event counter; clear with a coincident event leaves 1.
  always_ff @(posedge clk) begin
    if (rst)                        o_cnt <= 8'd0;
    else if (i_clr)                 o_cnt <= {7'd0, w_set};
    else if (w_set && o_cnt != 8'hFF) o_cnt <= o_cnt + 8'd1;
  end
`endif

endmodule

// ---------------------------------------------------------------------------
// Top: shared warm-up counter, array of channel slices, interrupt OR.
// ---------------------------------------------------------------------------
module edge_detect_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     a,
  input  logic [2*CH-1:0]   mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CH-1:0]     evt_clr,
  output logic [CH-1:0]     rise,
  output logic [CH-1:0]     down,
  output logic [CH-1:0]     evt_pend,
  output logic              irq
`ifdef EDGE_DETECT_CNT_EN
  ,
  output logic [8*CH-1:0]   evt_cnt
`endif
);

  localparam int WW = $clog2(SYNC_STAGES + 1);

  logic [WW-1:0] r_warm;
  logic          w_warm;

  assign w_warm = (r_warm != '0);

  // Warm-up: after reset, let the sync chains fill before edges are reported.
  always_ff @(posedge clk) begin
    if (rst)         r_warm <= WW'(SYNC_STAGES);
    else if (w_warm) r_warm <= r_warm - WW'(1);
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    edge_detect_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_a        (a[g]),
      .i_warm     (w_warm),
      .i_mode     (mode[2*g +: 2]),
      .i_filt_len (filt_len),
      .i_clr      (evt_clr[g]),
      .o_rise     (rise[g]),
      .o_down     (down[g]),
      .o_pend     (evt_pend[g])
`ifdef EDGE_DETECT_CNT_EN
      ,
      .o_cnt      (evt_cnt[8*g +: 8])
`endif
    );
  end

  assign irq = |evt_pend;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed test-plan scenarios plus randomized traffic,
// all cycles compared against a behavioural model of the pin-to-event rules.
module tb_edge_detect_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   a;
  logic [2*CH-1:0] mode;
  logic [FW-1:0]   filt_len;
  logic [CH-1:0]   evt_clr;
  logic [CH-1:0]   rise;
  logic [CH-1:0]   down;
  logic [CH-1:0]   evt_pend;
  logic            irq;
`ifdef EDGE_DETECT_CNT_EN
  logic [8*CH-1:0] evt_cnt;
`endif

  always #5 clk = ~clk;

  edge_detect_multi #(.CH(CH), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .mode     (mode),
    .filt_len (filt_len),
    .evt_clr  (evt_clr),
    .rise     (rise),
    .down     (down),
    .evt_pend (evt_pend),
    .irq      (irq)
`ifdef EDGE_DETECT_CNT_EN
    ,
    .evt_cnt  (evt_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  // Pin samples are delayed by SS clocks; the filtered level changes once the
  // delayed pin has disagreed with it for more than filt_len consecutive clocks.
  logic [CH-1:0] m_hist[$];   // m_hist[0] = what the synchroniser currently presents
  bit   [CH-1:0] m_lvl, m_rise, m_down, m_pend;
  int            m_run[CH];
  int            m_cnt[CH];
  int            m_warm;

  function automatic void model_step();
    logic [CH-1:0] so;
    bit            set;
    if (rst) begin
      m_hist.delete();
      for (int k = 0; k < SS; k++) m_hist.push_back('0);
      m_lvl = '0; m_rise = '0; m_down = '0; m_pend = '0;
      m_warm = SS;
      for (int i = 0; i < CH; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
      return;
    end
    so = m_hist[0];
    m_hist.push_back(a);
    void'(m_hist.pop_front());
    m_rise = '0; m_down = '0;
    for (int i = 0; i < CH; i++) begin
      if (m_warm == 0) begin
        if (so[i] == m_lvl[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] > int'(filt_len)) begin
            m_lvl[i] = so[i];
            m_run[i] = 0;
            if (so[i]) m_rise[i] = 1'b1; else m_down[i] = 1'b1;
          end
        end
      end
      set = (m_rise[i] && mode[2*i]) || (m_down[i] && mode[2*i+1]);
      if (set) begin
        m_pend[i] = 1'b1;
        m_cnt[i]  = evt_clr[i] ? 1 : (m_cnt[i] >= 255 ? 255 : m_cnt[i] + 1);
      end else if (evt_clr[i]) begin
        m_pend[i] = 1'b0;
        m_cnt[i]  = 0;
      end
    end
    if (m_warm > 0) begin
      m_lvl = m_hist[0];
      m_warm--;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
    end
  endfunction

  // One clock: advance model on the edge, compare everything half a cycle later.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("rise", rise, m_rise);
    chk("down", down, m_down);
    chk("pend", evt_pend, m_pend);
    chk("irq", irq, |m_pend);
`ifdef EDGE_DETECT_CNT_EN
    for (int i = 0; i < CH; i++) chk("cnt", evt_cnt[8*i +: 8], m_cnt[i]);
`endif
  endtask

  initial begin
    rst = 1'b1; a = 4'hF; mode = 8'h55; filt_len = '0; evt_clr = '0;

    // 1: inputs high through reset, no spurious rise
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t1_no_rise", rise, 4'h0);
      chk("t1_no_pend", evt_pend, 4'h0);
    end
    // filtered level must be 1: dropping the pins gives down after 3 edges
    a = 4'h0;
    tick(); tick();
    chk("t1_down_early", down, 4'h0);
    tick();
    chk("t1_down_lat", down, 4'hF);
    chk("t1_down_nopend", evt_pend, 4'h0);
    repeat (3) tick();

    // 2: basic rise latency, filt_len 0
    a = 4'h1;
    tick(); tick();
    chk("t2_rise_early", rise, 4'h0);
    tick();
    chk("t2_rise", rise, 4'h1);
    chk("t2_pend", evt_pend, 4'h1);
    chk("t2_irq", irq, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t2_no_down", down[0], 1'b0);
    end

    // 3: glitch filter, filt_len 3
    filt_len = 4'd3;
    a = 4'h3; repeat (3) tick();
    a = 4'h1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("t3_glitch_rej", rise[1], 1'b0);
    end
    a = 4'h3;
    repeat (5) tick();
    chk("t3_rise_early", rise[1], 1'b0);
    tick();
    chk("t3_rise_lat", rise[1], 1'b1);
    repeat (4) tick();
    a = 4'h1;
    repeat (5) tick();
    chk("t3_down_early", down[1], 1'b0);
    tick();
    chk("t3_down_lat", down[1], 1'b1);
    repeat (3) tick();

    // 4: fall-only mode on ch2
    filt_len = '0; mode = 8'h65;
    evt_clr = 4'hF; tick(); evt_clr = '0;
    a = 4'h5;
    repeat (3) tick();
    chk("t4_rise", rise[2], 1'b1);
    chk("t4_pend_rise", evt_pend[2], 1'b0);
    repeat (5) tick();
    a = 4'h1;
    repeat (3) tick();
    chk("t4_down", down[2], 1'b1);
    chk("t4_pend_fall", evt_pend[2], 1'b1);
    repeat (5) tick();

    // 5: clear coincident with an event on ch3, then a plain clear
    evt_clr = 4'h8; a = 4'h9;
    repeat (3) tick();
    chk("t5_rise", rise[3], 1'b1);
    chk("t5_set_wins", evt_pend[3], 1'b1);
    evt_clr = 4'hF;
    tick();
    chk("t5_cleared", evt_pend, 4'h0);
    chk("t5_irq_low", irq, 1'b0);
    evt_clr = '0;

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) a = CH'($urandom);
      if (c % 53 == 0) filt_len = FW'($urandom_range(0, 4));
      if (c % 37 == 0) mode = 8'($urandom);
      evt_clr = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      tick();
    end
    evt_clr = '0;

`ifdef EDGE_DETECT_CNT_EN
    // 6: counter saturation, clear, clear with coincident edge
    filt_len = '0; mode = 8'h67; a = '0;
    repeat (6) tick();
    evt_clr = 4'h1; tick(); evt_clr = '0;
    for (int t = 0; t < 300; t++) begin
      a[0] = ~a[0];
      tick(); tick();
    end
    repeat (4) tick();
    chk("t6_sat", evt_cnt[7:0], 8'd255);
    evt_clr = 4'h1; tick(); evt_clr = '0;
    chk("t6_clr", evt_cnt[7:0], 8'd0);
    a[0] = ~a[0];
    tick(); tick();
    evt_clr = 4'h1; tick(); evt_clr = '0;
    chk("t6_clr_edge", evt_cnt[7:0], 8'd1);
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
